// File: rtl/s2mm_arb_pkg.sv
// Shared types, widths and status-field positions for the S2MM channel arbiter.
// Imported by the arbiter top and its order FIFO.
package s2mm_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } arb_state_t;

    localparam int STS_TAG_LSB = 0;
    localparam int STS_TAG_MSB = 3;
    localparam int STS_INTERR  = 4;
    localparam int STS_DECERR  = 5;
    localparam int STS_SLVERR  = 6;
    localparam int STS_OKAY    = 7;

    function automatic int cmd_w(input int addr_w);
        return addr_w + 40;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_order_fifo.sv
// Register-based first-word-fall-through FIFO holding channel indices.
// Records the order in which commands were granted.
module arb_order_fifo
    import s2mm_arb_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW   = clog2_min1(DEPTH);
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CNTW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage write; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/s2mm_channel_arbiter.sv
// Shares one S2MM datamover between NUM_CH backends: round-robin command
// grants, in-order data forwarding and status return to the issuing channel.
module s2mm_channel_arbiter
    import s2mm_arb_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int MM_ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [NUM_CH*(MM_ADDR_WIDTH+40)-1:0]  s_cmd_tdata,
    input  logic [NUM_CH-1:0]                     s_cmd_tvalid,
    output logic [NUM_CH-1:0]                     s_cmd_tready,
    output logic [MM_ADDR_WIDTH+40-1:0]           m_cmd_tdata,
    output logic                                  m_cmd_tvalid,
    input  logic                                  m_cmd_tready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic [NUM_CH*DATA_WIDTH/8-1:0]        s_axis_tkeep,
    input  logic [NUM_CH-1:0]                     s_axis_tlast,
    input  logic [NUM_CH-1:0]                     s_axis_tvalid,
    output logic [NUM_CH-1:0]                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]               m_axis_tkeep,
    output logic                                  m_axis_tlast,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    input  logic [7:0]                            s_sts_tdata,
    input  logic                                  s_sts_tkeep,
    input  logic                                  s_sts_tlast,
    input  logic                                  s_sts_tvalid,
    output logic                                  s_sts_tready,
    input  logic                                  s_sts_err,
    output logic [NUM_CH*8-1:0]                   m_sts_tdata,
    output logic [NUM_CH-1:0]                     m_sts_tkeep,
    output logic [NUM_CH-1:0]                     m_sts_tlast,
    output logic [NUM_CH-1:0]                     m_sts_tvalid,
    input  logic [NUM_CH-1:0]                     m_sts_tready,
    output logic [NUM_CH-1:0]                     m_sts_err,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding,
    output logic                                  orphan_sts
);

    localparam int CW = cmd_w(MM_ADDR_WIDTH);
    localparam int KW = DATA_WIDTH / 8;
    localparam int IW = clog2_min1(NUM_CH);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_t     state;
    arb_state_t     state_nxt;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  gnt;
    logic           any_req;
    logic           grant_fire;
    logic [CW-1:0]  cmd_reg;
    int             idx;

    logic           dq_full;
    logic           dq_empty;
    logic           dq_pop;
    logic [IW-1:0]  dq_head;
    logic [OW-1:0]  dq_count_unused;
    logic           sq_full;
    logic           sq_empty;
    logic           sq_pop;
    logic [IW-1:0]  sq_head;
    logic [OW-1:0]  sq_count;

    // First requesting channel at or after the rr pointer, with wrap
    always_comb begin
        gnt     = rr_ptr;
        any_req = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!any_req && s_cmd_tvalid[idx]) begin
                any_req = 1'b1;
                gnt     = IW'(idx);
            end
        end
    end

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant in IDLE when both order queues have room; hold cmd until accepted
    always_comb begin
        state_nxt    = state;
        grant_fire   = 1'b0;
        m_cmd_tvalid = 1'b0;
        s_cmd_tready = '0;
        unique case (state)
            ARB_IDLE: begin
                if (rstn && any_req && !dq_full && !sq_full) begin
                    grant_fire        = 1'b1;
                    s_cmd_tready[gnt] = 1'b1;
                    state_nxt         = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                m_cmd_tvalid = 1'b1;
                if (m_cmd_tready) begin
                    state_nxt = ARB_IDLE;
                end
            end
        endcase
    end

    // Capture the granted cmd word and advance the rr pointer past the grantee
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr  <= '0;
            cmd_reg <= '0;
        end else if (grant_fire) begin
            cmd_reg <= s_cmd_tdata[gnt*CW +: CW];
            rr_ptr  <= (gnt == IW'(NUM_CH - 1)) ? '0 : gnt + IW'(1);
        end
    end

    assign m_cmd_tdata = cmd_reg;

    arb_order_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_data_order (
        .clk       (clk),
        .rstn      (rstn),
        .push      (grant_fire),
        .push_data (gnt),
        .pop       (dq_pop),
        .pop_data  (dq_head),
        .count     (dq_count_unused),
        .full      (dq_full),
        .empty     (dq_empty)
    );

    arb_order_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_sts_order (
        .clk       (clk),
        .rstn      (rstn),
        .push      (grant_fire),
        .push_data (gnt),
        .pop       (sq_pop),
        .pop_data  (sq_head),
        .count     (sq_count),
        .full      (sq_full),
        .empty     (sq_empty)
    );

    // Data path follows the oldest granted channel; others are held off
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (rstn && !dq_empty) begin
            m_axis_tdata           = s_axis_tdata[dq_head*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tkeep           = s_axis_tkeep[dq_head*KW +: KW];
            m_axis_tlast           = s_axis_tlast[dq_head];
            m_axis_tvalid          = s_axis_tvalid[dq_head];
            s_axis_tready[dq_head] = m_axis_tready;
        end
    end

    assign dq_pop = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Status goes to the channel of the oldest unacknowledged cmd; strays are sunk
    always_comb begin
        m_sts_tdata  = '0;
        m_sts_tkeep  = '0;
        m_sts_tlast  = '0;
        m_sts_tvalid = '0;
        s_sts_tready = 1'b0;
        if (rstn) begin
            if (sq_empty) begin
                s_sts_tready = 1'b1;
            end else begin
                m_sts_tdata[sq_head*8 +: 8] = s_sts_tdata;
                m_sts_tkeep[sq_head]        = s_sts_tkeep;
                m_sts_tlast[sq_head]        = s_sts_tlast;
                m_sts_tvalid[sq_head]       = s_sts_tvalid;
                s_sts_tready                = m_sts_tready[sq_head];
            end
        end
    end

    assign sq_pop = !sq_empty && s_sts_tvalid && s_sts_tready && s_sts_tlast;

    // Sticky flag for status that arrived with no cmd pending
    always_ff @(posedge clk) begin
        if (!rstn) begin
            orphan_sts <= 1'b0;
        end else if (sq_empty && s_sts_tvalid) begin
            orphan_sts <= 1'b1;
        end
    end

    assign m_sts_err   = {NUM_CH{s_sts_err}};
    assign outstanding = sq_count;

endmodule

// File: tb/tb_s2mm_channel_arbiter.sv
// Randomized self-checking bench for s2mm_channel_arbiter (2 channels).
// Expected values come from a small order/occupancy model kept here.
module tb_s2mm_channel_arbiter;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int CW  = AW + 40;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int MO  = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NCH*CW-1:0] s_cmd_tdata;
    logic [NCH-1:0]    s_cmd_tvalid;
    logic [NCH-1:0]    s_cmd_tready;
    logic [CW-1:0]     m_cmd_tdata;
    logic              m_cmd_tvalid;
    logic              m_cmd_tready;
    logic [NCH*DW-1:0] s_axis_tdata;
    logic [NCH*KW-1:0] s_axis_tkeep;
    logic [NCH-1:0]    s_axis_tlast;
    logic [NCH-1:0]    s_axis_tvalid;
    logic [NCH-1:0]    s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [7:0]        s_sts_tdata;
    logic              s_sts_tkeep;
    logic              s_sts_tlast;
    logic              s_sts_tvalid;
    logic              s_sts_tready;
    logic              s_sts_err;
    logic [NCH*8-1:0]  m_sts_tdata;
    logic [NCH-1:0]    m_sts_tkeep;
    logic [NCH-1:0]    m_sts_tlast;
    logic [NCH-1:0]    m_sts_tvalid;
    logic [NCH-1:0]    m_sts_tready;
    logic [NCH-1:0]    m_sts_err;
    logic [2:0]        outstanding;
    logic              orphan_sts;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    s2mm_channel_arbiter #(
        .NUM_CH          (NCH),
        .MM_ADDR_WIDTH   (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_cmd_tdata   (s_cmd_tdata),
        .s_cmd_tvalid  (s_cmd_tvalid),
        .s_cmd_tready  (s_cmd_tready),
        .m_cmd_tdata   (m_cmd_tdata),
        .m_cmd_tvalid  (m_cmd_tvalid),
        .m_cmd_tready  (m_cmd_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .s_sts_tdata   (s_sts_tdata),
        .s_sts_tkeep   (s_sts_tkeep),
        .s_sts_tlast   (s_sts_tlast),
        .s_sts_tvalid  (s_sts_tvalid),
        .s_sts_tready  (s_sts_tready),
        .s_sts_err     (s_sts_err),
        .m_sts_tdata   (m_sts_tdata),
        .m_sts_tkeep   (m_sts_tkeep),
        .m_sts_tlast   (m_sts_tlast),
        .m_sts_tvalid  (m_sts_tvalid),
        .m_sts_tready  (m_sts_tready),
        .m_sts_err     (m_sts_err),
        .outstanding   (outstanding),
        .orphan_sts    (orphan_sts)
    );

    function automatic logic [CW-1:0] rand_cmd();
        return CW'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic clear_inputs();
        s_cmd_tdata   = '0;
        s_cmd_tvalid  = '0;
        m_cmd_tready  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        s_axis_tvalid = '0;
        m_axis_tready = 1'b0;
        s_sts_tdata   = '0;
        s_sts_tkeep   = 1'b0;
        s_sts_tlast   = 1'b0;
        s_sts_tvalid  = 1'b0;
        s_sts_err     = 1'b0;
        m_sts_tready  = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        s_cmd_tvalid = 2'b11;
        s_sts_tvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (m_cmd_tvalid !== 1'b0 || s_cmd_tready !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_cmd: m_cmd_tvalid=%b s_cmd_tready=%b expected 0/00", m_cmd_tvalid, s_cmd_tready);
        end
        vectors++;
        if (s_sts_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: sts_rdy=%b axis_v=%b axis_rdy=%b expected all 0", s_sts_tready, m_axis_tvalid, s_axis_tready);
        end
        vectors++;
        if (outstanding !== 3'd0 || orphan_sts !== 1'b0 || m_sts_tvalid !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state: outstanding=%0d orphan=%b m_sts_v=%b expected 0", outstanding, orphan_sts, m_sts_tvalid);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_inputs();
    endtask

    task automatic test_rr_grants();
        logic [CW-1:0] word [2];
        logic [CW-1:0] pend;
        logic [1:0]    exp_rdy;
        int            rr;
        int            issued;
        bit            in_flight;
        do_reset();
        rr        = 0;
        issued    = 0;
        in_flight = 0;
        pend      = '0;
        word[0]   = rand_cmd();
        word[1]   = rand_cmd();
        s_cmd_tdata  = {word[1], word[0]};
        s_cmd_tvalid = 2'b11;
        for (int cyc = 0; cyc < 30; cyc++) begin
            m_cmd_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_rdy = 2'b00;
            if (!in_flight && issued < MO) begin
                exp_rdy = 2'(1 << rr);
            end
            vectors++;
            if (s_cmd_tready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rr_tready cyc%0d: got %b expected %b", cyc, s_cmd_tready, exp_rdy);
            end
            vectors++;
            if (m_cmd_tvalid !== in_flight || outstanding !== 3'(issued)) begin
                miscompares++;
                $display("FAIL rr_state cyc%0d: m_cmd_tvalid=%b outstanding=%0d expected %b/%0d", cyc, m_cmd_tvalid, outstanding, in_flight, issued);
            end
            if (in_flight) begin
                vectors++;
                if (m_cmd_tdata !== pend) begin
                    miscompares++;
                    $display("FAIL rr_tdata cyc%0d: got %h expected %h", cyc, m_cmd_tdata, pend);
                end
            end
            @(posedge clk);
            #1;
            if (in_flight) begin
                if (m_cmd_tready) begin
                    in_flight = 0;
                end
            end else if (exp_rdy != 2'b00) begin
                pend        = word[rr];
                in_flight   = 1;
                issued++;
                word[rr]    = rand_cmd();
                s_cmd_tdata = {word[1], word[0]};
                rr          = (rr + 1) % NCH;
            end
        end
        clear_inputs();
    endtask

    task automatic test_data_order();
        logic [DW-1:0] pd [2][4];
        logic [KW-1:0] pk [2][4];
        int            bi [2];
        int            n;
        int            src;
        bit            ok;
        do_reset();
        m_cmd_tready = 1'b1;
        s_cmd_tdata  = {rand_cmd(), rand_cmd()};
        s_cmd_tvalid = 2'b10;
        ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (s_cmd_tready === 2'b10) ok = 1;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL order_cmd_ch1: got no grant expected s_cmd_tready=10");
        end
        s_cmd_tvalid = 2'b01;
        ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (s_cmd_tready === 2'b01) ok = 1;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL order_cmd_ch0: got no grant expected s_cmd_tready=01");
        end
        s_cmd_tvalid = 2'b00;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 4; k++) begin
                pd[c][k] = $urandom();
                pk[c][k] = KW'($urandom());
            end
            bi[c] = 0;
        end
        n = 0;
        m_axis_tready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                s_axis_tvalid[c]         = (bi[c] < 4);
                s_axis_tdata[c*DW +: DW] = pd[c][bi[c] % 4];
                s_axis_tkeep[c*KW +: KW] = pk[c][bi[c] % 4];
                s_axis_tlast[c]          = (bi[c] == 3);
            end
            @(negedge clk);
            if (n < 8) begin
                src = (n < 4) ? 1 : 0;
                vectors++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd[src][n%4] ||
                    m_axis_tkeep !== pk[src][n%4] || m_axis_tlast !== (n % 4 == 3)) begin
                    miscompares++;
                    $display("FAIL order_beat%0d: v=%b d=%h k=%h l=%b expected v=1 d=%h k=%h ch%0d", n,
                             m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, pd[src][n%4], pk[src][n%4], src);
                end
                vectors++;
                if (s_axis_tready !== 2'(1 << src)) begin
                    miscompares++;
                    $display("FAIL order_ready%0d: got %b expected %b", n, s_axis_tready, 2'(1 << src));
                end
            end else begin
                vectors++;
                if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 2'b00) begin
                    miscompares++;
                    $display("FAIL order_idle: v=%b rdy=%b expected 0/00", m_axis_tvalid, s_axis_tready);
                end
            end
            @(posedge clk);
            #1;
            if (n < 8) begin
                bi[(n < 4) ? 1 : 0]++;
                n++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_status_route();
        logic [7:0] sts;
        logic [1:0] seen [2];
        int         g;
        do_reset();
        m_cmd_tready = 1'b1;
        s_cmd_tdata  = {rand_cmd(), rand_cmd()};
        s_cmd_tvalid = 2'b11;
        g = 0;
        seen[0] = 2'b00;
        seen[1] = 2'b00;
        for (int i = 0; i < 10 && g < 2; i++) begin
            @(negedge clk);
            if (s_cmd_tready !== 2'b00) begin
                seen[g] = s_cmd_tready;
                g++;
            end
            @(posedge clk);
            #1;
            if (g == 2) s_cmd_tvalid = 2'b00;
        end
        s_cmd_tvalid = 2'b00;
        vectors++;
        if (seen[0] !== 2'b01 || seen[1] !== 2'b10) begin
            miscompares++;
            $display("FAIL sts_issue_order: got %b,%b expected 01,10", seen[0], seen[1]);
        end
        @(negedge clk);
        vectors++;
        if (outstanding !== 3'd2) begin
            miscompares++;
            $display("FAIL sts_outstanding_2: got %0d expected 2", outstanding);
        end
        @(posedge clk);
        #1;
        sts          = 8'h80 | 8'($urandom_range(0, 15));
        s_sts_tdata  = sts;
        s_sts_tkeep  = 1'b1;
        s_sts_tlast  = 1'b1;
        s_sts_tvalid = 1'b1;
        s_sts_err    = 1'b1;
        m_sts_tready = 2'b10;
        @(negedge clk);
        vectors++;
        if (m_sts_tvalid !== 2'b01 || s_sts_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL sts_backpressure: v=%b rdy=%b expected 01/0", m_sts_tvalid, s_sts_tready);
        end
        @(posedge clk);
        #1;
        m_sts_tready = 2'b11;
        @(negedge clk);
        vectors++;
        if (m_sts_tvalid !== 2'b01 || m_sts_tdata !== {8'h00, sts} || s_sts_tready !== 1'b1 || m_sts_err !== 2'b11) begin
            miscompares++;
            $display("FAIL sts_beat0: v=%b d=%h rdy=%b err=%b expected 01/%h/1/11", m_sts_tvalid, m_sts_tdata, s_sts_tready, m_sts_err, {8'h00, sts});
        end
        @(posedge clk);
        #1;
        sts         = 8'h80 | 8'($urandom_range(0, 15));
        s_sts_tdata = sts;
        s_sts_err   = 1'b0;
        @(negedge clk);
        vectors++;
        if (outstanding !== 3'd1) begin
            miscompares++;
            $display("FAIL sts_outstanding_1: got %0d expected 1", outstanding);
        end
        vectors++;
        if (m_sts_tvalid !== 2'b10 || m_sts_tdata !== {sts, 8'h00} || m_sts_tlast !== 2'b10 || m_sts_err !== 2'b00) begin
            miscompares++;
            $display("FAIL sts_beat1: v=%b d=%h l=%b err=%b expected 10/%h/10/00", m_sts_tvalid, m_sts_tdata, m_sts_tlast, m_sts_err, {sts, 8'h00});
        end
        @(posedge clk);
        #1;
        s_sts_tvalid = 1'b0;
        @(negedge clk);
        vectors++;
        if (outstanding !== 3'd0 || orphan_sts !== 1'b0) begin
            miscompares++;
            $display("FAIL sts_drained: outstanding=%0d orphan=%b expected 0/0", outstanding, orphan_sts);
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_outstanding_limit();
        int grants;
        do_reset();
        m_cmd_tready = 1'b1;
        s_cmd_tdata  = {rand_cmd(), rand_cmd()};
        s_cmd_tvalid = 2'b01;
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (s_cmd_tready[0] === 1'b1) grants++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (grants !== MO || outstanding !== 3'(MO)) begin
            miscompares++;
            $display("FAIL limit_fill: grants=%0d outstanding=%0d expected %0d", grants, outstanding, MO);
        end
        @(negedge clk);
        vectors++;
        if (s_cmd_tready !== 2'b00) begin
            miscompares++;
            $display("FAIL limit_blocked: s_cmd_tready=%b expected 00", s_cmd_tready);
        end
        @(posedge clk);
        #1;
        s_sts_tdata   = 8'h80;
        s_sts_tkeep   = 1'b1;
        s_sts_tlast   = 1'b1;
        s_sts_tvalid  = 1'b1;
        m_sts_tready  = 2'b01;
        s_axis_tdata  = {2{32'($urandom())}};
        s_axis_tkeep  = '1;
        s_axis_tvalid = 2'b01;
        s_axis_tlast  = 2'b01;
        m_axis_tready = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_sts_tready !== 1'b1 || s_axis_tready !== 2'b01 || s_cmd_tready !== 2'b00) begin
            miscompares++;
            $display("FAIL limit_drain: sts_rdy=%b axis_rdy=%b cmd_rdy=%b expected 1/01/00", s_sts_tready, s_axis_tready, s_cmd_tready);
        end
        @(posedge clk);
        #1;
        s_sts_tvalid  = 1'b0;
        s_axis_tvalid = 2'b00;
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_cmd_tready[0] === 1'b1) grants++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (grants !== 1 || outstanding !== 3'(MO)) begin
            miscompares++;
            $display("FAIL limit_refill: grants=%0d outstanding=%0d expected 1/%0d", grants, outstanding, MO);
        end
        clear_inputs();
    endtask

    task automatic test_orphan();
        do_reset();
        s_sts_tdata  = 8'($urandom());
        s_sts_tkeep  = 1'b1;
        s_sts_tlast  = 1'b1;
        s_sts_tvalid = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_sts_tready !== 1'b1 || m_sts_tvalid !== 2'b00) begin
            miscompares++;
            $display("FAIL orphan_accept: rdy=%b m_sts_v=%b expected 1/00", s_sts_tready, m_sts_tvalid);
        end
        @(posedge clk);
        #1;
        s_sts_tvalid = 1'b0;
        @(negedge clk);
        vectors++;
        if (orphan_sts !== 1'b1 || outstanding !== 3'd0) begin
            miscompares++;
            $display("FAIL orphan_set: orphan=%b outstanding=%0d expected 1/0", orphan_sts, outstanding);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (orphan_sts !== 1'b1) begin
            miscompares++;
            $display("FAIL orphan_sticky: got %b expected 1", orphan_sts);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        bit ok;
        do_reset();
        m_cmd_tready = 1'b1;
        s_sts_tvalid = 1'b1;
        s_sts_tlast  = 1'b1;
        @(posedge clk);
        #1;
        s_sts_tvalid = 1'b0;
        s_cmd_tdata  = {rand_cmd(), rand_cmd()};
        s_cmd_tvalid = 2'b01;
        ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (s_cmd_tready === 2'b01) ok = 1;
            @(posedge clk);
            #1;
        end
        s_cmd_tvalid = 2'b00;
        @(posedge clk);
        #1;
        m_cmd_tready = 1'b0;
        s_cmd_tvalid = 2'b01;
        for (int i = 0; i < 8 && ok; i++) begin
            @(negedge clk);
            if (s_cmd_tready === 2'b01) ok = 0;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (ok) begin
            miscompares++;
            $display("FAIL mreset_setup: got missing grant expected two ch0 grants");
        end
        s_cmd_tvalid  = 2'b11;
        s_axis_tdata  = {2{32'($urandom())}};
        s_axis_tkeep  = '1;
        s_axis_tvalid = 2'b01;
        s_axis_tlast  = 2'b00;
        m_axis_tready = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_axis_tready !== 2'b01 || m_cmd_tvalid !== 1'b1 || outstanding !== 3'd2 || orphan_sts !== 1'b1) begin
            miscompares++;
            $display("FAIL mreset_before: axis_rdy=%b cmd_v=%b outstanding=%0d orphan=%b expected 01/1/2/1",
                     s_axis_tready, m_cmd_tvalid, outstanding, orphan_sts);
        end
        @(posedge clk);
        #1;
        rstn         = 1'b0;
        s_sts_tvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (m_cmd_tvalid !== 1'b0 || s_cmd_tready !== 2'b00 || s_axis_tready !== 2'b00 ||
            s_sts_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL mreset_outputs: cmd_v=%b cmd_rdy=%b axis_rdy=%b sts_rdy=%b axis_v=%b expected all 0",
                     m_cmd_tvalid, s_cmd_tready, s_axis_tready, s_sts_tready, m_axis_tvalid);
        end
        vectors++;
        if (outstanding !== 3'd0 || orphan_sts !== 1'b0) begin
            miscompares++;
            $display("FAIL mreset_state: outstanding=%0d orphan=%b expected 0/0", outstanding, orphan_sts);
        end
        @(posedge clk);
        #1;
        rstn          = 1'b1;
        s_sts_tvalid  = 1'b0;
        s_axis_tvalid = 2'b00;
        m_cmd_tready  = 1'b1;
        s_cmd_tvalid  = 2'b11;
        @(negedge clk);
        vectors++;
        if (s_cmd_tready !== 2'b01) begin
            miscompares++;
            $display("FAIL mreset_rr: got %b expected 01", s_cmd_tready);
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        clear_inputs();
        test_reset();
        test_rr_grants();
        test_data_order();
        test_status_route();
        test_outstanding_limit();
        test_orphan();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
